// File: rtl/cpu_pkg.sv
// Shared core package: writeback source select, load funct3 encodings and
// writeback FSM states.
package cpu_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// Writeback stage bus: memory-stage handshake, load response and register
// file write port. master = upstream/environment side, slave = writeback_stage.
interface writeback_stage_if #(parameter int XLEN = 64) ();
  logic            mem_valid_i;
  logic            mem_ready_o;
  logic            mem_wr_reg_en_i;
  logic [4:0]      mem_rd_i;
  logic [1:0]      mem_wb_sel_i;
  logic [XLEN-1:0] mem_alu_result_i;
  logic [XLEN-1:0] mem_pc_i;
  logic [2:0]      mem_funct3_i;
  logic [2:0]      mem_addr_lo_i;
  logic            dmem_rsp_valid_i;
  logic [XLEN-1:0] dmem_rsp_data_i;
  logic            wr_reg_en_o;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] rd_data_o;
  logic [63:0]     retire_cnt_o;

  modport master (
    output mem_valid_i, mem_wr_reg_en_i, mem_rd_i, mem_wb_sel_i,
           mem_alu_result_i, mem_pc_i, mem_funct3_i, mem_addr_lo_i,
           dmem_rsp_valid_i, dmem_rsp_data_i,
    input  mem_ready_o, wr_reg_en_o, rd_o, rd_data_o, retire_cnt_o
  );

  modport slave (
    input  mem_valid_i, mem_wr_reg_en_i, mem_rd_i, mem_wb_sel_i,
           mem_alu_result_i, mem_pc_i, mem_funct3_i, mem_addr_lo_i,
           dmem_rsp_valid_i, dmem_rsp_data_i,
    output mem_ready_o, wr_reg_en_o, rd_o, rd_data_o, retire_cnt_o
  );
endinterface

// File: rtl/writeback_stage_load_extend.sv
// Combinational load data extraction and sign/zero extension from an
// aligned doubleword; funct3 = 111 yields zero.
module load_extend
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] data,
  output logic [63:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] word_s;

  assign byte_s = data[{addr_lo, 3'b000} +: 8];
  assign half_s = data[{addr_lo[2:1], 4'b0000} +: 16];
  assign word_s = data[{addr_lo[2], 5'b00000} +: 32];

  // Select access size and extension
  always_comb begin
    ext = 64'd0;
    case (funct3)
      F3_LB:   ext = {{56{byte_s[7]}}, byte_s};
      F3_LH:   ext = {{48{half_s[15]}}, half_s};
      F3_LW:   ext = {{32{word_s[31]}}, word_s};
      F3_LD:   ext = data;
      F3_LBU:  ext = {56'd0, byte_s};
      F3_LHU:  ext = {48'd0, half_s};
      F3_LWU:  ext = {32'd0, word_s};
      default: ext = 64'd0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// RV64 writeback stage: accepts completed instructions, waits for load data
// and drives a registered register-file write port. Optional retired-instruction
// counter is built when WB_RETIRE_CNT_EN is defined.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic              clk_i,
  input logic              rst_i,
  writeback_stage_if.slave wb
);

  wb_state_e       state_r, next_state_s;
  logic            wr_en_r, wr_en_s;
  logic [4:0]      rd_r, rd_s;
  logic [XLEN-1:0] data_r, data_s;
  logic            ld_en_r;
  logic [4:0]      ld_rd_r;
  logic [2:0]      ld_f3_r;
  logic [2:0]      ld_addr_r;
  logic [XLEN-1:0] ld_ext_s;
  logic            accept_ld_s;

  load_extend u_load_extend (
    .funct3  (ld_f3_r),
    .addr_lo (ld_addr_r),
    .data    (wb.dmem_rsp_data_i),
    .ext     (ld_ext_s)
  );

  assign accept_ld_s = (state_r == WB_IDLE) && wb.mem_valid_i && (wb.mem_wb_sel_i == WB_LOAD);

  // State and registered write port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= WB_IDLE;
      wr_en_r <= 1'b0;
      rd_r    <= 5'd0;
      data_r  <= {XLEN{1'b0}};
    end else begin
      state_r <= next_state_s;
      wr_en_r <= wr_en_s;
      rd_r    <= rd_s;
      data_r  <= data_s;
    end
  end

  // Pending load attributes captured on acceptance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_en_r   <= 1'b0;
      ld_rd_r   <= 5'd0;
      ld_f3_r   <= 3'd0;
      ld_addr_r <= 3'd0;
    end else if (accept_ld_s) begin
      ld_en_r   <= wb.mem_wr_reg_en_i;
      ld_rd_r   <= wb.mem_rd_i;
      ld_f3_r   <= wb.mem_funct3_i;
      ld_addr_r <= wb.mem_addr_lo_i;
    end else begin
      ld_en_r   <= ld_en_r;
      ld_rd_r   <= ld_rd_r;
      ld_f3_r   <= ld_f3_r;
      ld_addr_r <= ld_addr_r;
    end
  end

  // Next state and next write-port values; rd/data stay zero without a write
  always_comb begin
    next_state_s = state_r;
    wr_en_s      = 1'b0;
    rd_s         = 5'd0;
    data_s       = {XLEN{1'b0}};
    case (state_r)
      WB_IDLE: begin
        if (accept_ld_s) begin
          next_state_s = WB_WAIT_LOAD;
        end else if (wb.mem_valid_i && wb.mem_wr_reg_en_i && (wb.mem_rd_i != 5'd0)) begin
          wr_en_s = 1'b1;
          rd_s    = wb.mem_rd_i;
          data_s  = (wb.mem_wb_sel_i == WB_PC4) ? (wb.mem_pc_i + 64'd4) : wb.mem_alu_result_i;
        end else begin
          next_state_s = WB_IDLE;
        end
      end
      WB_WAIT_LOAD: begin
        if (wb.dmem_rsp_valid_i) begin
          next_state_s = WB_IDLE;
          if (ld_en_r && (ld_rd_r != 5'd0)) begin
            wr_en_s = 1'b1;
            rd_s    = ld_rd_r;
            data_s  = ld_ext_s;
          end else begin
            wr_en_s = 1'b0;
          end
        end else begin
          next_state_s = WB_WAIT_LOAD;
        end
      end
      default: next_state_s = WB_IDLE;
    endcase
  end

  assign wb.mem_ready_o = (state_r == WB_IDLE);
  assign wb.wr_reg_en_o = wr_en_r;
  assign wb.rd_o        = rd_r;
  assign wb.rd_data_o   = data_r;

`ifdef WB_RETIRE_CNT_EN
  logic        retire_s;
  logic [63:0] retire_cnt_r;

  assign retire_s = ((state_r == WB_IDLE) && wb.mem_valid_i && (wb.mem_wb_sel_i != WB_LOAD))
                 || ((state_r == WB_WAIT_LOAD) && wb.dmem_rsp_valid_i);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retire_cnt_r <= 64'd0;
    end else if (retire_s) begin
      retire_cnt_r <= retire_cnt_r + 64'd1;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign wb.retire_cnt_o = retire_cnt_r;
`else
  assign wb.retire_cnt_o = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against a cycle-level
// reference model of the writeback rules.
module tb_writeback_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  writeback_stage_if #(.XLEN(64)) bus ();

  writeback_stage #(.XLEN(64)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_busy;
  bit          p_en;
  logic [4:0]  p_rd;
  logic [2:0]  p_f3, p_a;
  bit          e_wr;
  logic [4:0]  e_rd;
  logic [63:0] e_data;
  logic [63:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_ext(input logic [2:0] f3, input logic [2:0] a, input logic [63:0] d);
    int sz, off;
    logic [63:0] v, m;
    if (f3 == 3'd7) return 64'd0;
    sz  = 1 << f3[1:0];
    off = (int'(a) / sz) * sz;
    v   = d >> (8 * off);
    if (sz == 8) return v;
    m = (64'd1 << (8 * sz)) - 64'd1;
    v = v & m;
    if (!f3[2] && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  task automatic cyc(input bit r, input bit v, input bit en, input logic [4:0] rd,
                     input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] pc,
                     input logic [2:0] f3, input logic [2:0] a,
                     input bit rsp, input logic [63:0] rdata);
    rst                  = r;
    bus.mem_valid_i      = v;
    bus.mem_wr_reg_en_i  = en;
    bus.mem_rd_i         = rd;
    bus.mem_wb_sel_i     = sel;
    bus.mem_alu_result_i = alu;
    bus.mem_pc_i         = pc;
    bus.mem_funct3_i     = f3;
    bus.mem_addr_lo_i    = a;
    bus.dmem_rsp_valid_i = rsp;
    bus.dmem_rsp_data_i  = rdata;
    e_wr = 1'b0; e_rd = 5'd0; e_data = 64'd0;
    if (r) begin
      m_busy = 1'b0;
      m_cnt  = 64'd0;
    end else if (!m_busy) begin
      if (v && sel == 2'b01) begin
        m_busy = 1'b1; p_en = en; p_rd = rd; p_f3 = f3; p_a = a;
      end else if (v) begin
        m_cnt = m_cnt + 64'd1;
        if (en && rd != 5'd0) begin
          e_wr = 1'b1; e_rd = rd;
          e_data = (sel == 2'b10) ? pc + 64'd4 : alu;
        end
      end
    end else if (rsp) begin
      m_busy = 1'b0;
      m_cnt  = m_cnt + 64'd1;
      if (p_en && p_rd != 5'd0) begin
        e_wr = 1'b1; e_rd = p_rd; e_data = ref_ext(p_f3, p_a, rdata);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("wr_en", {63'd0, bus.wr_reg_en_o}, {63'd0, e_wr});
    check("rd", {59'd0, bus.rd_o}, {59'd0, e_rd});
    check("rd_data", bus.rd_data_o, e_data);
    check("ready", {63'd0, bus.mem_ready_o}, {63'd0, !m_busy});
`ifdef WB_RETIRE_CNT_EN
    check("retire_cnt", bus.retire_cnt_o, m_cnt);
`else
    check("retire_cnt", bus.retire_cnt_o, 64'd0);
`endif
  endtask

  task automatic idle();
    cyc(0, 0, 0, 5'd0, 2'b00, 64'd0, 64'd0, 3'd0, 3'd0, 0, 64'd0);
  endtask
  task automatic reset_cyc();
    cyc(1, 0, 0, 5'd0, 2'b00, 64'd0, 64'd0, 3'd0, 3'd0, 0, 64'd0);
  endtask
  task automatic alu_op(input logic [4:0] rd, input logic [1:0] sel, input logic [63:0] val, input logic [63:0] pc);
    cyc(0, 1, 1, rd, sel, val, pc, 3'd0, 3'd0, 0, 64'd0);
  endtask
  task automatic load_op(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] a);
    cyc(0, 1, 1, rd, 2'b01, 64'd0, 64'd0, f3, a, 0, 64'd0);
  endtask
  task automatic resp(input logic [63:0] d);
    cyc(0, 0, 0, 5'd0, 2'b00, 64'd0, 64'd0, 3'd0, 3'd0, 1, d);
  endtask

  initial begin
    m_busy = 1'b0; m_cnt = 64'd0;
    p_en = 1'b0; p_rd = 5'd0; p_f3 = 3'd0; p_a = 3'd0;
    reset_cyc();
    reset_cyc();
    check("reset_ready", {63'd0, bus.mem_ready_o}, 64'd1);

    alu_op(5'd5, 2'b00, 64'h1234, 64'h100);
    check("alu_data", bus.rd_data_o, 64'h1234);
    idle();

    load_op(5'd7, 3'b000, 3'd3);
    check("lb_wait_ready", {63'd0, bus.mem_ready_o}, 64'd0);
    resp(64'h0000_0000_8000_0000);
    check("lb_data", bus.rd_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    load_op(5'd7, 3'b100, 3'd3);
    idle();
    resp(64'h0000_0000_8000_0000);
    check("lbu_data", bus.rd_data_o, 64'h0000_0000_0000_0080);

    load_op(5'd9, 3'b010, 3'd4);
    resp(64'h8765_4321_0000_0000);
    check("lw_data", bus.rd_data_o, 64'hFFFF_FFFF_8765_4321);
    load_op(5'd9, 3'b110, 3'd4);
    resp(64'h8765_4321_0000_0000);
    check("lwu_data", bus.rd_data_o, 64'h0000_0000_8765_4321);
    load_op(5'd9, 3'b101, 3'd6);
    resp(64'h8765_4321_0000_0000);
    check("lhu_data", bus.rd_data_o, 64'h0000_0000_0000_8765);
    load_op(5'd9, 3'b111, 3'd0);
    resp(64'hFFFF_FFFF_FFFF_FFFF);
    check("illegal_f3_wr", {63'd0, bus.wr_reg_en_o}, 64'd1);

    alu_op(5'd0, 2'b00, 64'hDEAD, 64'd0);
    check("rd0_nowrite", {63'd0, bus.wr_reg_en_o}, 64'd0);
    alu_op(5'd1, 2'b10, 64'h5555, 64'hFFFF_FFFF_FFFF_FFFC);
    check("jal_wrap", bus.rd_data_o, 64'd0);

    // Load interrupted by reset, response arrives after reset
    load_op(5'd3, 3'b011, 3'd0);
    idle();
    reset_cyc();
    resp(64'h1111_2222_3333_4444);
    check("rst_ld_nowrite", {63'd0, bus.wr_reg_en_o}, 64'd0);
    check("rst_ld_ready", {63'd0, bus.mem_ready_o}, 64'd1);
    check("rst_ld_cnt", bus.retire_cnt_o, 64'd0);

    alu_op(5'd2, 2'b00, 64'd1, 64'd0);
    alu_op(5'd0, 2'b00, 64'd2, 64'd0);
    alu_op(5'd4, 2'b11, 64'd3, 64'd0);
    alu_op(5'd6, 2'b10, 64'd4, 64'h40);
    load_op(5'd8, 3'b011, 3'd0);
    resp(64'hCAFE_F00D_1234_5678);
`ifdef WB_RETIRE_CNT_EN
    check("cnt5", bus.retire_cnt_o, 64'd5);
`else
    check("cnt5", bus.retire_cnt_o, 64'd0);
`endif

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
          5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
          {$urandom, $urandom}, {$urandom, $urandom},
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 2) == 0), {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
